// File: rtl/logicnets_io_pkg.sv
// Shared definitions for the LogicNets layer-boundary handshake stages.
// Holds the skid-buffer state encoding and default bus/counter widths.
// Imported by every layer boundary stage so the encoding stays consistent.
package logicnets_io_pkg;

  // Encoding doubles as the held-sample count (EMPTY=0, ONE=1, FULL=2).
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_t;

  localparam int LN_WIDTH = 64;
  localparam int LN_CNT_W = 16;

endpackage

// File: rtl/layer1_out_stage.sv
// Purpose : registered 2-entry skid buffer between layer-1 neuron LUTs and layer-2 fan-in.
// Latency : sample accepted at edge n is on out_data with out_valid=1 after edge n.
// Backpr. : absorbs one extra sample into skid after out_ready drops; in_ready is registered.
module layer1_out_stage
  import logicnets_io_pkg::*;
#(
  parameter int WIDTH = LN_WIDTH,
  parameter int CNT_W = LN_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             flush,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] sample_cnt
);

  skid_state_t      r_state;
  skid_state_t      w_state_nxt;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic [CNT_W-1:0] r_cnt;

  logic w_accept;
  logic w_deliver;
  logic w_main_ld_in;
  logic w_main_ld_skid;
  logic w_skid_ld;

  // Handshake flags come from registered state only, so in_ready never depends on out_ready.
  assign in_ready   = (r_state != ST_FULL);
  assign out_valid  = (r_state != ST_EMPTY);
  assign out_data   = r_main;
  assign occupancy  = 2'(r_state);
  assign sample_cnt = r_cnt;

  assign w_accept  = in_valid && in_ready;
  assign w_deliver = out_valid && out_ready;

  // State register; held samples are lost on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and data-register load enables; flush overrides everything except the count.
  always_comb begin
    w_state_nxt    = r_state;
    w_main_ld_in   = 1'b0;
    w_main_ld_skid = 1'b0;
    w_skid_ld      = 1'b0;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_state_nxt  = ST_ONE;
            w_main_ld_in = 1'b1;
          end
        end
        ST_ONE: begin
          if (w_accept && !w_deliver) begin
            w_state_nxt = ST_FULL;
            w_skid_ld   = 1'b1;
          end else if (!w_accept && w_deliver) begin
            w_state_nxt = ST_EMPTY;
          end else if (w_accept && w_deliver) begin
            w_main_ld_in = 1'b1;
          end
        end
        ST_FULL: begin
          if (w_deliver) begin
            w_state_nxt    = ST_ONE;
            w_main_ld_skid = 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_EMPTY;
        end
      endcase
    end
  end

  // Data registers are not reset; their contents only matter while marked valid.
  always_ff @(posedge clk) begin
    if (w_main_ld_in) begin
      r_main <= in_data;
    end else if (w_main_ld_skid) begin
      r_main <= r_skid;
    end
    if (w_skid_ld) begin
      r_skid <= in_data;
    end
  end

  // Delivered-sample counter; a deliver in a flush cycle still completed, so it counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_deliver) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_layer1_out_stage.sv
// Directed bench for layer1_out_stage: streaming, back-pressure, flush, counter wrap, async reset.
// Inputs change 1 ns after the rising edge; outputs are sampled at that same point.
// A second instance with a 4-bit counter shares all inputs to exercise counter wrap.
module tb_layer1_out_stage;

  localparam int W = 64;

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  in_data;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic          flush;
  logic [1:0]    occupancy;
  logic [15:0]   sample_cnt;

  logic          in_ready4;
  logic [W-1:0]  out_data4;
  logic          out_valid4;
  logic [1:0]    occupancy4;
  logic [3:0]    sample_cnt4;

  int n_tests = 0;
  int n_fail  = 0;

  layer1_out_stage #(.WIDTH(W), .CNT_W(16)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .flush      (flush),
    .occupancy  (occupancy),
    .sample_cnt (sample_cnt)
  );

  layer1_out_stage #(.WIDTH(W), .CNT_W(4)) u_dut_c4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready4),
    .out_data   (out_data4),
    .out_valid  (out_valid4),
    .out_ready  (out_ready),
    .flush      (flush),
    .occupancy  (occupancy4),
    .sample_cnt (sample_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;

    // ---------------- reset ----------------
    #3 rst_n = 1'b0;
    tick();
    tick();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_occ",       64'(occupancy), 64'd0);
    check("rst_cnt",       64'(sample_cnt), 64'd0);
    #2 rst_n = 1'b1;

    // ---------------- stream 8 samples with out_ready=1 ----------------
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_data  = 64'(i);
      in_valid = 1'b1;
      tick();
      check("stream_valid", 64'(out_valid), 64'd1);
      check("stream_data",  out_data,       64'(i));
      check("stream_occ",   64'(occupancy), 64'd1);
    end
    in_valid = 1'b0;
    tick();
    check("stream_drain_occ", 64'(occupancy),  64'd0);
    check("stream_cnt",       64'(sample_cnt), 64'd8);

    // ---------------- back-pressure: fill with AA, BB ----------------
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'hAA;
    tick();
    check("bp_first_rdy",  64'(in_ready), 64'd1);
    check("bp_first_data", out_data,      64'hAA);
    in_data = 64'hBB;
    tick();
    check("bp_full_rdy",  64'(in_ready),  64'd0);
    check("bp_full_occ",  64'(occupancy), 64'd2);
    check("bp_full_data", out_data,       64'hAA);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_drain1_data", out_data,       64'hBB);
    check("bp_drain1_occ",  64'(occupancy), 64'd1);
    tick();
    check("bp_drain2_occ", 64'(occupancy),  64'd0);
    check("bp_cnt",        64'(sample_cnt), 64'd10);

    // ---------------- FULL with out_ready and in_valid held high ----------------
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'h11;
    tick();
    in_data = 64'h22;
    tick();
    check("fh_full_occ", 64'(occupancy), 64'd2);
    out_ready = 1'b1;
    in_data   = 64'h33;
    tick();
    check("fh_d1_data", out_data,       64'h22);
    check("fh_d1_rdy",  64'(in_ready),  64'd1);
    check("fh_d1_occ",  64'(occupancy), 64'd1);
    tick();
    check("fh_d2_data", out_data, 64'h33);
    in_data = 64'h44;
    tick();
    check("fh_d3_data", out_data, 64'h44);
    in_valid = 1'b0;
    tick();
    check("fh_empty_occ", 64'(occupancy),  64'd0);
    check("fh_cnt",       64'(sample_cnt), 64'd14);

    // ---------------- flush in FULL with CC offered ----------------
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'h55;
    tick();
    in_data = 64'h66;
    tick();
    check("fl_full_occ", 64'(occupancy), 64'd2);
    flush   = 1'b1;
    in_data = 64'hCC;
    tick();
    check("fl_occ",   64'(occupancy),  64'd0);
    check("fl_valid", 64'(out_valid),  64'd0);
    check("fl_cnt",   64'(sample_cnt), 64'd14);
    flush     = 1'b0;
    out_ready = 1'b1;
    in_data   = 64'h77;
    tick();
    check("fl_next_data", out_data, 64'h77);
    in_valid = 1'b0;
    tick();
    check("fl_next_cnt", 64'(sample_cnt), 64'd15);
    // A deliver coinciding with flush still counts.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'h88;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    flush     = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_del_occ",  64'(occupancy),   64'd0);
    check("fl_del_cnt",  64'(sample_cnt),  64'd16);
    check("wrap16_cnt4", 64'(sample_cnt4), 64'd0);

    // ---------------- async reset mid-stream in ONE ----------------
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'h99;
    tick();
    check("ar_pre_valid", 64'(out_valid), 64'd1);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid", 64'(out_valid),  64'd0);
    check("ar_rdy",   64'(in_ready),   64'd1);
    check("ar_occ",   64'(occupancy),  64'd0);
    check("ar_cnt",   64'(sample_cnt), 64'd0);
    #2 rst_n = 1'b1;

    // ---------------- 17 delivers: 4-bit counter wraps to 1 ----------------
    tick();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_data = 64'(i + 16'h100);
      tick();
      check("c17_data", out_data, 64'(i + 16'h100));
    end
    in_valid = 1'b0;
    tick();
    check("c17_cnt16", 64'(sample_cnt),  64'd17);
    check("c17_cnt4",  64'(sample_cnt4), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
